// File: rtl/fft_pkg.sv
// Shared types, constants and helpers for the 16-point FFT frame sequencer.
package fft_pkg;

  localparam int unsigned NPT          = 16;
  localparam int unsigned LOG2N        = 4;
  localparam int unsigned BF_PER_STAGE = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    OUT,
    DONE
  } fft_state_t;

  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Radix-2 DIF butterfly address/twiddle generator: (stage, butterfly) -> operand addresses.
module fft_bf_addr_gen
  import fft_pkg::*;
(
  input  logic [1:0]       stage,
  input  logic [2:0]       bf_idx,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [2:0]       tw_idx
);

  // half = 8>>s: the group index fills the bits above the half bit, k the bits below,
  // so addr_b is addr_a with the half bit set.
  always_comb begin
    addr_a = '0;
    addr_b = '0;
    tw_idx = '0;
    unique case (stage)
      2'd0: begin
        addr_a = {1'b0, bf_idx};
        addr_b = {1'b1, bf_idx};
        tw_idx = bf_idx;
      end
      2'd1: begin
        addr_a = {bf_idx[2], 1'b0, bf_idx[1:0]};
        addr_b = {bf_idx[2], 1'b1, bf_idx[1:0]};
        tw_idx = {bf_idx[1:0], 1'b0};
      end
      2'd2: begin
        addr_a = {bf_idx[2:1], 1'b0, bf_idx[0]};
        addr_b = {bf_idx[2:1], 1'b1, bf_idx[0]};
        tw_idx = {bf_idx[0], 2'b00};
      end
      default: begin
        addr_a = {bf_idx, 1'b0};
        addr_b = {bf_idx, 1'b1};
        tw_idx = '0;
      end
    endcase
  end

endmodule

// File: rtl/fft_frame_seq.sv
// Frame sequencer: load strobe, 4x8 butterfly schedule with per-stage drain,
// 16 bit-reversed result reads; overrun frames are dropped and counted.
module fft_frame_seq
  import fft_pkg::*;
#(
  parameter int unsigned BF_LAT = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       stp_valid,
  output logic       load_en,
  output logic       bf_valid,
  output logic [1:0] bf_stage,
  output logic [3:0] bf_addr_a,
  output logic [3:0] bf_addr_b,
  output logic [2:0] bf_tw_idx,
  output logic       rd_en,
  output logic [3:0] rd_addr,
  output logic [3:0] out_idx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] drop_cnt
);

  fft_state_t state, nxt_state;
  logic [1:0] stage, nxt_stage;
  logic [3:0] cnt, nxt_cnt;
  logic [7:0] nxt_drop;

  logic [3:0] gen_a, gen_b;
  logic [2:0] gen_tw;

  logic       n_load, n_bf, n_rd, n_busy, n_done;
  logic [1:0] n_stage;
  logic [3:0] n_a, n_b, n_rd_addr, n_out_idx;
  logic [2:0] n_tw;

  // The address generator sees the next-cycle counters so its result lands in the
  // output registers in the same cycle the matching state is entered.
  fft_bf_addr_gen u_addr_gen (
    .stage  (nxt_stage),
    .bf_idx (nxt_cnt[2:0]),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  always_comb begin
    nxt_state = state;
    nxt_stage = stage;
    nxt_cnt   = cnt;
    unique case (state)
      IDLE: if (stp_valid) nxt_state = LOAD;
      LOAD: begin
        nxt_state = RUN;
        nxt_stage = '0;
        nxt_cnt   = '0;
      end
      RUN: begin
        if (cnt == 4'(BF_PER_STAGE - 1)) begin
          nxt_state = DRAIN;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 4'd1;
        end
      end
      DRAIN: begin
        if (cnt == 4'(BF_LAT - 1)) begin
          nxt_cnt = '0;
          if (stage == 2'd3) begin
            nxt_state = OUT;
          end else begin
            nxt_state = RUN;
            nxt_stage = stage + 2'd1;
          end
        end else begin
          nxt_cnt = cnt + 4'd1;
        end
      end
      OUT: begin
        if (cnt == 4'(NPT - 1)) begin
          nxt_state = DONE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 4'd1;
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    nxt_drop = drop_cnt;
    if (stp_valid && (state != IDLE) && (drop_cnt != '1))
      nxt_drop = drop_cnt + 8'd1;
  end

  always_comb begin
    n_load    = (nxt_state == LOAD);
    n_bf      = (nxt_state == RUN);
    n_rd      = (nxt_state == OUT);
    n_done    = (nxt_state == DONE);
    n_busy    = (nxt_state != IDLE);
    n_stage   = n_bf ? nxt_stage : '0;
    n_a       = n_bf ? gen_a : '0;
    n_b       = n_bf ? gen_b : '0;
    n_tw      = n_bf ? gen_tw : '0;
    n_out_idx = n_rd ? nxt_cnt : '0;
    n_rd_addr = n_rd ? bitrev4(nxt_cnt) : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      stage      <= '0;
      cnt        <= '0;
      drop_cnt   <= '0;
      load_en    <= 1'b0;
      bf_valid   <= 1'b0;
      bf_stage   <= '0;
      bf_addr_a  <= '0;
      bf_addr_b  <= '0;
      bf_tw_idx  <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      out_idx    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      stage      <= nxt_stage;
      cnt        <= nxt_cnt;
      drop_cnt   <= nxt_drop;
      load_en    <= n_load;
      bf_valid   <= n_bf;
      bf_stage   <= n_stage;
      bf_addr_a  <= n_a;
      bf_addr_b  <= n_b;
      bf_tw_idx  <= n_tw;
      rd_en      <= n_rd;
      rd_addr    <= n_rd_addr;
      out_idx    <= n_out_idx;
      busy       <= n_busy;
      frame_done <= n_done;
    end
  end

endmodule

// File: tb/tb_fft_frame_seq.sv
// Directed bench for fft_frame_seq: schedule, addressing, overrun, reset, BF_LAT=5.
module tb_fft_frame_seq;

  logic CLK = 1'b0;
  logic RST;
  logic stp2, stp5;

  logic       ld2, bf2, rd2, bz2, dn2;
  logic [1:0] st2;
  logic [3:0] a2, b2, ra2, oi2;
  logic [2:0] tw2;
  logic [7:0] dc2;

  logic       ld5, bf5, rd5, bz5, dn5;
  logic [1:0] st5;
  logic [3:0] a5, b5, ra5, oi5;
  logic [2:0] tw5;
  logic [7:0] dc5;

  fft_frame_seq #(.BF_LAT(2)) dut (
    .CLK(CLK), .RST(RST), .stp_valid(stp2),
    .load_en(ld2), .bf_valid(bf2), .bf_stage(st2), .bf_addr_a(a2), .bf_addr_b(b2),
    .bf_tw_idx(tw2), .rd_en(rd2), .rd_addr(ra2), .out_idx(oi2), .busy(bz2),
    .frame_done(dn2), .drop_cnt(dc2)
  );

  fft_frame_seq #(.BF_LAT(5)) dut5 (
    .CLK(CLK), .RST(RST), .stp_valid(stp5),
    .load_en(ld5), .bf_valid(bf5), .bf_stage(st5), .bf_addr_a(a5), .bf_addr_b(b5),
    .bf_tw_idx(tw5), .rd_en(rd5), .rd_addr(ra5), .out_idx(oi5), .busy(bz5),
    .frame_done(dn5), .drop_cnt(dc5)
  );

  always #5 CLK = ~CLK;

  logic        sel5;
  logic [6:0]  o_strb;
  logic [10:0] o_addr;
  logic [3:0]  o_ra, o_oi;
  logic [33:0] all2, all5;

  assign all2 = {ld2, bf2, st2, a2, b2, tw2, rd2, ra2, oi2, bz2, dn2, dc2};
  assign all5 = {ld5, bf5, st5, a5, b5, tw5, rd5, ra5, oi5, bz5, dn5, dc5};

  always_comb begin
    o_strb = sel5 ? {ld5, bf5, rd5, dn5, bz5, st5} : {ld2, bf2, rd2, dn2, bz2, st2};
    o_addr = sel5 ? {a5, b5, tw5} : {a2, b2, tw2};
    o_ra   = sel5 ? ra5 : ra2;
    o_oi   = sel5 ? oi5 : oi2;
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Expected {load,bf,rd,done,busy,stage} r cycles after the accepting edge.
  function automatic logic [6:0] exp_strb(input int r, input int lat);
    int p, rs, rr;
    logic ld, bf, rd, dn, bz;
    logic [1:0] st;
    p  = 8 + lat;
    rs = 2 + 4 * p;
    rr = r - 2;
    ld = (r == 1);
    bf = (rr >= 0) && (rr < 4 * p) && ((rr % p) < 8);
    st = bf ? 2'(rr / p) : 2'd0;
    rd = (r >= rs) && (r < rs + 16);
    dn = (r == rs + 16);
    bz = (r >= 1) && (r <= rs + 16);
    return {ld, bf, rd, dn, bz, st};
  endfunction

  task automatic frame(input int lat, input int nr);
    int rs;
    logic [6:0] e;
    rs = 2 + 4 * (8 + lat);
    if (lat == 5) stp5 = 1'b1; else stp2 = 1'b1;
    step();
    stp2 = 1'b0;
    stp5 = 1'b0;
    for (int r = 1; r <= nr; r++) begin
      e = exp_strb(r, lat);
      check($sformatf("strb L%0d r%0d", lat, r), 64'(o_strb), 64'(e));
      if (!e[5]) check($sformatf("addr0 L%0d r%0d", lat, r), 64'(o_addr), 64'd0);
      if (e[4]) check($sformatf("oidx L%0d r%0d", lat, r), 64'(o_oi), 64'(r - rs));
      else      check($sformatf("rd0 L%0d r%0d", lat, r), 64'({o_ra, o_oi}), 64'd0);
      if (lat == 2) begin
        case (r)
          5:  check("addr s0b3", 64'(o_addr), 64'({4'd3,  4'd11, 3'd3}));
          17: check("addr s1b5", 64'(o_addr), 64'({4'd9,  4'd13, 3'd2}));
          27: check("addr s2b5", 64'(o_addr), 64'({4'd9,  4'd11, 3'd4}));
          28: check("addr s2b6", 64'(o_addr), 64'({4'd12, 4'd14, 3'd0}));
          39: check("addr s3b7", 64'(o_addr), 64'({4'd14, 4'd15, 3'd0}));
          43: check("rdaddr i1",  64'(o_ra), 64'd8);
          48: check("rdaddr i6",  64'(o_ra), 64'd6);
          53: check("rdaddr i11", 64'(o_ra), 64'd13);
          default: ;
        endcase
      end
      step();
    end
  endtask

  initial begin
    logic seen_done;
    RST  = 1'b1;
    stp2 = 1'b0;
    stp5 = 1'b0;
    sel5 = 1'b0;
    cyc  = 0;
    repeat (3) step();
    check("reset lat2", 64'(all2), 64'd0);
    check("reset lat5", 64'(all5), 64'd0);
    RST = 1'b0;

    // Single frame accepted at edge 10.
    cyc = 0;
    while (cyc < 9) step();
    frame(2, 62);

    // Pulses every 16 cycles from edge 10: 26/42/58 dropped, 74 accepted.
    cyc = 0;
    for (int e = 1; e <= 135; e++) begin
      stp2 = (e >= 10) && (e <= 74) && (((e - 10) % 16) == 0);
      step();
      stp2 = 1'b0;
      if (e == 57)  check("drop after 42", 64'(dc2), 64'd2);
      if (e == 58)  check("drop after 58", 64'(dc2), 64'd3);
      if (e == 67)  check("done frame1", 64'(dn2), 64'd1);
      if (e == 74)  check("load frame2", 64'(ld2), 64'd1);
      if (e == 131) check("done frame2", 64'(dn2), 64'd1);
      if (e == 132) check("busy low frame2", 64'(bz2), 64'd0);
    end
    check("drop final overrun", 64'(dc2), 64'd3);

    // stp_valid held high: one accept per 59 cycles, everything else dropped.
    stp2 = 1'b1;
    repeat (120) step();
    check("drop after 120", 64'(dc2), 64'd120);
    repeat (200) step();
    stp2 = 1'b0;
    check("drop saturated", 64'(dc2), 64'd255);
    repeat (100) step();
    check("drop held", 64'(dc2), 64'd255);
    check("idle after sat", 64'(bz2), 64'd0);

    RST = 1'b1;
    step();
    check("reset clears all", 64'(all2), 64'd0);
    RST = 1'b0;

    // Reset during stage 2 RUN abandons the frame.
    stp2 = 1'b1;
    step();
    stp2 = 1'b0;
    repeat (23) step();
    check("pre-reset stage2", 64'(o_strb), 64'(exp_strb(24, 2)));
    RST = 1'b1;
    step();
    check("midframe reset", 64'(all2), 64'd0);
    RST = 1'b0;
    seen_done = 1'b0;
    repeat (70) begin
      step();
      seen_done = seen_done | dn2 | bz2;
    end
    check("no done after reset", 64'(seen_done), 64'd0);
    frame(2, 60);

    // BF_LAT=5 instance.
    sel5 = 1'b1;
    frame(5, 74);
    check("drop lat5", 64'(dc5), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
